// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_stream_engine
//  Description : Parametrised bit-serial CRC engine over valid/ready framed
//                word streams; one CRC result per frame. Optional macro
//                CRC_STREAM_CHECK_EN adds a registered compare against
//                crc_expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_engine #(
    parameter int                CRC_W  = 8,
    parameter int                DATA_W = 8,
    parameter logic [CRC_W-1:0]  POLY   = 8'h31,
    parameter logic [CRC_W-1:0]  INIT   = 8'hFF,
    parameter logic [CRC_W-1:0]  XOROUT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy
`ifdef CRC_STREAM_CHECK_EN
    ,
    input  logic [CRC_W-1:0]  crc_expected,
    output logic              crc_match
`endif
);

    localparam int                 c_cnt_w    = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CRC_W-1:0]   r_crc;
    logic [c_cnt_w-1:0] r_count;
    logic               r_last;
    logic               r_out_valid;
    logic [CRC_W-1:0]   r_crc_out;

    logic [CRC_W-1:0]   w_base;
    logic [CRC_W-1:0]   w_word;
    logic [CRC_W-1:0]   w_shifted;
    logic               w_last_shift;
    logic               w_done_entry;
    logic               w_done_exit;

    // Word is aligned to the register MSB so it is consumed MSB first.
    assign w_base       = in_first ? INIT : r_crc;
    assign w_word       = CRC_W'(in_data) << (CRC_W - DATA_W);
    assign w_shifted    = {r_crc[CRC_W-2:0], 1'b0} ^ (r_crc[CRC_W-1] ? POLY : '0);
    assign w_last_shift = (r_state == S_SHIFT) && (r_count == c_last_cnt);
    assign w_done_entry = w_last_shift && r_last;
    assign w_done_exit  = (r_state == S_DONE) && out_ready;

    assign in_ready  = (r_state == S_WAIT);
    assign busy      = (r_state != S_WAIT);
    assign out_valid = r_out_valid;
    assign crc_out   = r_crc_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_WAIT;
            r_crc       <= INIT;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_crc_out   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (in_valid) begin
                        r_crc   <= w_base ^ w_word;
                        r_last  <= in_last;
                        r_count <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_crc   <= w_shifted;
                    r_count <= r_count + c_cnt_one;
                    if (w_last_shift) begin
                        if (r_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_crc_out   <= w_shifted ^ XOROUT;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    // Result is held until consumed; input stays stalled meanwhile.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_WAIT;
                        r_crc       <= INIT;
                    end
                end
                default: begin
                    r_state     <= S_WAIT;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRC_STREAM_CHECK_EN
    logic r_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match <= 1'b0;
        end else if (w_done_entry) begin
            r_match <= ((w_shifted ^ XOROUT) == crc_expected);
        end else if (w_done_exit) begin
            r_match <= 1'b0;
        end
    end

    assign crc_match = r_match;
`else
    logic w_unused_exit;
    assign w_unused_exit = w_done_exit;
`endif

endmodule
`default_nettype wire
